// File: rtl/scanout_streamer.sv
// -----------------------------------------------------------------------------
// scanout_streamer
//   Walks the PPU band memories in raster order and streams a whole frame of
//   30-bit pixels on an Avalon-ST source (readyLatency 0).
//   Each band memory holds VGA_HEIGHT/CORES_COUNT lines.
//
// Ports
//   clk, resetn      clock; asynchronous active-low reset
//   enable           level; a frame starts while high, frames are never cut
//   mode             0 RGB565, 1 RGB555, 2 GRAY8, 3 colour-bar test pattern
//   rdata            band memory read data, valid RD_LATENCY cycles after address
//   raddress         pixel address inside the selected band
//   rselect          selected band memory
//   m_data           R[29:20] G[19:10] B[9:0]
//   m_startofpacket  first pixel of frame
//   m_endofpacket    last pixel of frame
//   m_valid/m_ready  Avalon-ST handshake
//   frame_done       one-cycle pulse when the eop beat is accepted
// -----------------------------------------------------------------------------
module scanout_streamer #(
   parameter int VGA_WIDTH     = 800,
   parameter int VGA_HEIGHT    = 600,
   parameter int CORES_COUNT   = 10,
   parameter int BUFFER_ADDR_W = 32,
   parameter int COLOR_WIDTH   = 16,
   parameter int RD_LATENCY    = 1,
   parameter int FIFO_DEPTH_W  = 3
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           enable,
   input  logic [1:0]                     mode,
   input  logic [COLOR_WIDTH-1:0]         rdata,
   output logic [BUFFER_ADDR_W-1:0]       raddress,
   output logic [$clog2(CORES_COUNT)-1:0] rselect,
   output logic [29:0]                    m_data,
   output logic                           m_startofpacket,
   output logic                           m_endofpacket,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic                           frame_done
);

   // ---------------------------------------------------------------- checks
   if (VGA_HEIGHT % CORES_COUNT != 0) begin : g_chk_bands
      $error("VGA_HEIGHT must be a multiple of CORES_COUNT");
   end
   if (COLOR_WIDTH != 16) begin : g_chk_color
      $error("COLOR_WIDTH must be 16");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_chk_lat
      $error("RD_LATENCY must be in 1..4");
   end
   if ((2**FIFO_DEPTH_W) < RD_LATENCY + 1) begin : g_chk_fifo
      $error("2**FIFO_DEPTH_W must be >= RD_LATENCY+1");
   end

   // ------------------------------------------------------------ constants
   localparam int          SEL_W  = $clog2(CORES_COUNT);
   localparam int          DEPTH  = 2**FIFO_DEPTH_W;
   localparam int          CNT_W  = FIFO_DEPTH_W + 1;
   localparam logic [31:0] X_LAST = 32'(VGA_WIDTH - 1);
   localparam logic [31:0] Y_LAST = 32'(VGA_HEIGHT - 1);
   localparam logic [31:0] A_LAST = 32'(VGA_WIDTH * (VGA_HEIGHT / CORES_COUNT) - 1);
   localparam logic [31:0] W_U    = 32'(VGA_WIDTH);
   localparam logic [SEL_W-1:0] S_LAST = SEL_W'(CORES_COUNT - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   // Tag travelling alongside each outstanding read.
   typedef struct packed {
      logic       v;
      logic       sop;
      logic       eop;
      logic [1:0] mode;
      logic [2:0] bar;
   } rd_tag_t;

   // --------------------------------------------------------------- signals
   state_t                  r_state, w_next_state;
   logic [31:0]             r_x, r_y, r_addr;
   logic [SEL_W-1:0]        r_sel;
   logic [1:0]              r_frame_mode;
   rd_tag_t                 r_pipe [RD_LATENCY];
   logic [31:0]             r_mem  [DEPTH];
   logic [FIFO_DEPTH_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]        r_count, r_credits;

   rd_tag_t     w_exit;
   logic        w_issue, w_sop_rd, w_eop_rd, w_push, w_pop, w_frame_start;
   logic [2:0]  w_bar;
   logic [29:0] w_pix;
   logic [31:0] w_head;

   function automatic logic [9:0] exp5(input logic [4:0] c);
      return {c, c};
   endfunction
   function automatic logic [9:0] exp6(input logic [5:0] c);
      return {c, c[5:2]};
   endfunction
   function automatic logic [9:0] exp8(input logic [7:0] c);
      return {c, c[7:6]};
   endfunction

   // ------------------------------------------------------- read issue side
   assign w_sop_rd = (r_x == 32'd0) && (r_y == 32'd0);
   assign w_eop_rd = (r_x == X_LAST) && (r_y == Y_LAST);
   assign w_bar    = 3'((r_x * 32'd8) / W_U);
   // Credits count FIFO entries plus reads in flight, as registered; a pop
   // in this cycle frees its credit only from the next cycle on.
   assign w_issue  = (r_state == S_RUN) && (r_credits < CNT_W'(DEPTH));

   assign raddress = BUFFER_ADDR_W'(r_addr);
   assign rselect  = r_sel;

   // --------------------------------------------------------- output side
   assign w_exit          = r_pipe[RD_LATENCY-1];
   assign w_push          = w_exit.v;
   assign m_valid         = (r_count != '0);
   assign w_pop           = m_valid && m_ready;
   assign w_head          = m_valid ? r_mem[r_rd_ptr] : 32'd0;
   assign m_startofpacket = w_head[31];
   assign m_endofpacket   = w_head[30];
   assign m_data          = w_head[29:0];
   assign frame_done      = w_pop && w_head[30];

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: state elements use non-blocking assignment so every register
      // samples pre-edge values, independent of block ordering.
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:  if (enable) w_next_state = S_RUN;
         S_RUN:   if (w_issue && w_eop_rd) w_next_state = S_DRAIN;
         S_DRAIN: if (frame_done) w_next_state = enable ? S_RUN : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   assign w_frame_start = (w_next_state == S_RUN) && (r_state != S_RUN);

   // ------------------------------------------------- address walk / mode
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_x          <= '0;
         r_y          <= '0;
         r_addr       <= '0;
         r_sel        <= '0;
         r_frame_mode <= '0;
      end else begin
         if (w_frame_start) r_frame_mode <= mode;
         if (w_issue) begin
            if (r_x == X_LAST) begin
               r_x <= '0;
               r_y <= (r_y == Y_LAST) ? 32'd0 : r_y + 32'd1;
            end else begin
               r_x <= r_x + 32'd1;
            end
            if (r_addr == A_LAST) begin
               r_addr <= '0;
               r_sel  <= (r_sel == S_LAST) ? '0 : r_sel + 1'b1;
            end else begin
               r_addr <= r_addr + 32'd1;
            end
         end
      end
   end

   // ------------------------------------------------ in-flight read pipe
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < RD_LATENCY; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= '{v: w_issue, sop: w_sop_rd, eop: w_eop_rd,
                        mode: r_frame_mode, bar: w_bar};
         for (int i = 1; i < RD_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   // ------------------------------------------------ pixel format convert
   always_comb begin
      w_pix = '0;
      case (w_exit.mode)
         2'd0:    w_pix = {exp5(rdata[15:11]), exp6(rdata[10:5]), exp5(rdata[4:0])};
         2'd1:    w_pix = {exp5(rdata[14:10]), exp5(rdata[9:5]), exp5(rdata[4:0])};
         2'd2:    w_pix = {3{exp8(rdata[7:0])}};
         default: w_pix = {{10{w_exit.bar[2]}}, {10{w_exit.bar[1]}}, {10{w_exit.bar[0]}}};
      endcase
   end

   // ---------------------------------------------------------- output FIFO
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_credits <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count   <= r_count   + CNT_W'(w_push)  - CNT_W'(w_pop);
         r_credits <= r_credits + CNT_W'(w_issue) - CNT_W'(w_pop);
      end
   end

   // NOTE: storage is not reset; emptiness comes from the reset pointers and
   // the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {w_exit.sop, w_exit.eop, w_pix};
   end

endmodule

// File: tb/tb_scanout_streamer.sv
// -----------------------------------------------------------------------------
// tb_scanout_streamer
//   Scoreboard bench: every frame expected from the DUT is pushed as a list of
//   beats before streaming starts; each accepted beat is popped and compared.
//   Band memory model returns {rselect, raddress[14:0]} after two cycles,
//   or a fixed override word.
// -----------------------------------------------------------------------------
module tb_scanout_streamer;

   localparam int W    = 8;
   localparam int H    = 4;
   localparam int C    = 2;
   localparam int L    = 2;
   localparam int FDW  = 2;
   localparam int NPIX = W * H;
   localparam int BAND = NPIX / C;

   logic        clk = 1'b0;
   logic        resetn, enable, m_ready;
   logic [1:0]  mode;
   logic [15:0] rdata;
   logic [31:0] raddress;
   logic [0:0]  rselect;
   logic [29:0] m_data;
   logic        m_startofpacket, m_endofpacket, m_valid, frame_done;

   always #5 clk = ~clk;

   scanout_streamer #(
      .VGA_WIDTH(W), .VGA_HEIGHT(H), .CORES_COUNT(C), .BUFFER_ADDR_W(32),
      .COLOR_WIDTH(16), .RD_LATENCY(L), .FIFO_DEPTH_W(FDW)
   ) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .mode(mode), .rdata(rdata),
      .raddress(raddress), .rselect(rselect), .m_data(m_data),
      .m_startofpacket(m_startofpacket), .m_endofpacket(m_endofpacket),
      .m_valid(m_valid), .m_ready(m_ready), .frame_done(frame_done)
   );

   // Band memory model, two-cycle read latency.
   logic [15:0] mem_d0, mem_d1, ovr_val;
   logic        ovr_en;
   always @(posedge clk) begin
      mem_d0 <= {rselect, raddress[14:0]};
      mem_d1 <= mem_d0;
   end
   assign rdata = ovr_en ? ovr_val : mem_d1;

   typedef struct {
      logic        sop;
      logic        eop;
      logic [29:0] data;
   } beat_t;

   beat_t       sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          beats, fd_count, duty, occ_max;
   logic        held_v;
   logic [31:0] held;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [9:0] x5(input logic [4:0] c);
      return {c, c};
   endfunction
   function automatic logic [9:0] x6(input logic [5:0] c);
      return {c, c[5:2]};
   endfunction
   function automatic logic [9:0] x8(input logic [7:0] c);
      return {c, c[7:6]};
   endfunction

   function automatic logic [29:0] model_pix(input int i, input logic [1:0] md,
                                             input logic oe, input logic [15:0] ov);
      int          x, band, addr, bar;
      logic [15:0] rd;
      logic [9:0]  r, g, b;
      x    = i % W;
      band = i / BAND;
      addr = i % BAND;
      rd   = oe ? ov : {band[0], 15'(addr)};
      case (md)
         2'd0: begin r = x5(rd[15:11]); g = x6(rd[10:5]); b = x5(rd[4:0]); end
         2'd1: begin r = x5(rd[14:10]); g = x5(rd[9:5]);  b = x5(rd[4:0]); end
         2'd2: begin r = x8(rd[7:0]);   g = r;            b = r;           end
         default: begin
            bar = (x * 8) / W;
            r = bar[2] ? 10'h3FF : 10'h000;
            g = bar[1] ? 10'h3FF : 10'h000;
            b = bar[0] ? 10'h3FF : 10'h000;
         end
      endcase
      return {r, g, b};
   endfunction

   task automatic push_frame(input logic [1:0] md, input logic oe, input logic [15:0] ov);
      for (int i = 0; i < NPIX; i++)
         sb_q.push_back('{sop: (i == 0), eop: (i == NPIX - 1), data: model_pix(i, md, oe, ov)});
   endtask

   // One clock: drive m_ready on the falling edge, sample 1 ns later.
   task automatic step();
      beat_t e;
      @(negedge clk);
      m_ready = ($urandom_range(0, 99) < duty);
      #1;
      if (int'(dut.r_count) > occ_max) occ_max = int'(dut.r_count);
      if (held_v) begin
         check("stall_valid", 32'(m_valid), 32'd1);
         check("stall_hold", {m_startofpacket, m_endofpacket, m_data}, held);
      end
      held_v = m_valid && !m_ready;
      held   = {m_startofpacket, m_endofpacket, m_data};
      if (frame_done) fd_count++;
      if (m_valid && m_ready) begin
         if (sb_q.size() == 0) begin
            check("extra_beat", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("beat_data", 32'(m_data), 32'(e.data));
            check("beat_sop", 32'(m_startofpacket), 32'(e.sop));
            check("beat_eop", 32'(m_endofpacket), 32'(e.eop));
            check("frame_done", 32'(frame_done), 32'(e.eop));
         end
         beats++;
      end
   endtask

   task automatic run_until(input int target, input int drop_at,
                            input int chg_at, input logic [1:0] chg_mode);
      int cyc = 0;
      while (beats < target && cyc < 3000) begin
         step();
         cyc++;
         if (beats >= drop_at) enable = 1'b0;
         if (chg_at >= 0 && beats >= chg_at) mode = chg_mode;
      end
      check("frame_beats", 32'(beats), 32'(target));
   endtask

   task automatic idle_check(input int frames);
      duty = 100;
      repeat (20) step();
      check("idle_valid", 32'(m_valid), 32'd0);
      check("idle_raddr", raddress, 32'd0);
      check("idle_rsel", 32'(rselect), 32'd0);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      check("done_pulses", 32'(fd_count), 32'(frames));
   endtask

   task automatic start(input logic [1:0] md, input int dt);
      beats = 0; fd_count = 0; occ_max = 0; held_v = 1'b0;
      duty = dt; mode = md;
      enable = 1'b1;
   endtask

   initial begin
      resetn = 1'b0; enable = 1'b0; mode = 2'd0; m_ready = 1'b0;
      ovr_en = 1'b0; ovr_val = 16'h0; duty = 100; held_v = 1'b0;
      beats = 0; fd_count = 0; occ_max = 0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_sop", 32'(m_startofpacket), 32'd0);
      check("rst_eop", 32'(m_endofpacket), 32'd0);
      check("rst_data", 32'(m_data), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_raddr", raddress, 32'd0);
      check("rst_rsel", 32'(rselect), 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Full-rate frame, enable dropped at beat 10: frame still completes.
      push_frame(2'd0, 1'b0, 16'h0);
      start(2'd0, 100);
      run_until(NPIX, 10, -1, 2'd0);
      idle_check(1);

      // Random 30% ready: same beats, stable while stalled, bounded FIFO.
      push_frame(2'd0, 1'b0, 16'h0);
      start(2'd0, 30);
      run_until(NPIX, 5, -1, 2'd0);
      check("fifo_occ_le4", 32'(occ_max <= 4), 32'd1);
      idle_check(1);

      // Fixed data words through RGB565 and GRAY8.
      ovr_en = 1'b1; ovr_val = 16'hF81F;
      push_frame(2'd0, 1'b1, 16'hF81F);
      start(2'd0, 100);
      run_until(NPIX, 1, -1, 2'd0);
      idle_check(1);
      ovr_val = 16'h0080;
      push_frame(2'd2, 1'b1, 16'h0080);
      start(2'd2, 100);
      run_until(NPIX, 1, -1, 2'd0);
      idle_check(1);
      ovr_en = 1'b0;

      // RGB555 frame.
      push_frame(2'd1, 1'b0, 16'h0);
      start(2'd1, 60);
      run_until(NPIX, 3, -1, 2'd0);
      idle_check(1);

      // Test pattern, mode switched to 0 mid-frame: applies to the next frame.
      push_frame(2'd3, 1'b0, 16'h0);
      push_frame(2'd0, 1'b0, 16'h0);
      start(2'd3, 70);
      run_until(2 * NPIX, NPIX + 8, 8, 2'd0);
      idle_check(2);

      // Reset at beat 20: outputs clear, next frame starts cleanly.
      push_frame(2'd0, 1'b0, 16'h0);
      start(2'd0, 100);
      run_until(20, 1, -1, 2'd0);
      resetn = 1'b0;
      #1;
      check("mid_rst_valid", 32'(m_valid), 32'd0);
      check("mid_rst_sop", 32'(m_startofpacket), 32'd0);
      check("mid_rst_eop", 32'(m_endofpacket), 32'd0);
      check("mid_rst_data", 32'(m_data), 32'd0);
      check("mid_rst_done", 32'(frame_done), 32'd0);
      sb_q.delete();
      held_v = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      #1;
      check("post_rst_raddr", raddress, 32'd0);
      check("post_rst_rsel", 32'(rselect), 32'd0);
      push_frame(2'd0, 1'b0, 16'h0);
      start(2'd0, 50);
      run_until(NPIX, 4, -1, 2'd0);
      idle_check(1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
